// File: rtl/x1_pkg.sv
// Shared definitions for the X1 IPL loader: FSM encoding and fill constants.
package x1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StRelease,
        StDone
    } ipl_state_e;

    // Unwritten IPL bytes are padded with this value.
    localparam logic [7:0] FillByte = 8'hFF;

    // byte_count saturates here instead of wrapping.
    localparam logic [13:0] ByteCountMax = 14'h3FFF;

endpackage

// File: rtl/x1_ipl_loader_if.sv
// Host download stream (ioctl_*) and IPL dpram write port (ipl_*).
interface x1_ipl_loader_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        ipl_we;
    logic [12:0] ipl_addr;
    logic [7:0]  ipl_data;

    // Host side: streams the file, observes the dpram writes.
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ipl_we, ipl_addr, ipl_data
    );

    // Loader side: consumes the stream, drives the dpram port.
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ipl_we, ipl_addr, ipl_data
    );

endinterface

// File: rtl/x1_ipl_loader.sv
// Copies the selected download into the IPL dpram, pads the rest of the window
// with 0xFF, then keeps the CPUs in reset for HOLD more cycles before release.
module x1_ipl_loader
    import x1_pkg::*;
#(
    parameter logic [7:0]  INDEX = 8'h00,
    parameter int unsigned SIZE  = 4096,
    parameter int unsigned HOLD  = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    x1_ipl_loader_if.slave    bus,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              overflow,
    output logic [13:0]       byte_count,
    output logic [7:0]        checksum
);

    localparam logic [24:0] SizeAddr = 25'(SIZE);
    localparam logic [13:0] SizePtr  = 14'(SIZE);
    localparam logic [15:0] HoldLast = 16'(HOLD - 1);

    ipl_state_e  r_state, w_state;
    logic        r_sel;
    logic        r_we, w_we;
    logic [12:0] r_addr, w_addr;
    logic [7:0]  r_data, w_data;
    logic        r_overflow, w_overflow;
    logic [13:0] r_count, w_count;
    logic [7:0]  r_sum, w_sum;
    logic [13:0] r_fill_ptr, w_fill_ptr;
    logic [15:0] r_rel_cnt, w_rel_cnt;

    logic        w_sel;
    logic        w_sel_rise;
    logic [13:0] w_addr_next;
    logic [13:0] w_fill_inc;

    assign w_sel       = bus.ioctl_download && (bus.ioctl_index == INDEX);
    assign w_sel_rise  = w_sel && !r_sel;
    assign w_addr_next = {1'b0, bus.ioctl_addr[12:0]} + 14'd1;
    assign w_fill_inc  = r_fill_ptr + 14'd1;

    // State and datapath registers; r_sel resets high so a download that is
    // still active when reset drops is not mistaken for a new one.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= StIdle;
            r_sel      <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_sum      <= '0;
            r_fill_ptr <= '0;
            r_rel_cnt  <= '0;
        end else begin
            r_state    <= w_state;
            r_sel      <= w_sel;
            r_we       <= w_we;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_overflow <= w_overflow;
            r_count    <= w_count;
            r_sum      <= w_sum;
            r_fill_ptr <= w_fill_ptr;
            r_rel_cnt  <= w_rel_cnt;
        end
    end

    // Next-state and write generation; a new selected download overrides all.
    always_comb begin
        w_state    = r_state;
        w_we       = 1'b0;
        w_addr     = r_addr;
        w_data     = r_data;
        w_overflow = r_overflow;
        w_count    = r_count;
        w_sum      = r_sum;
        w_fill_ptr = r_fill_ptr;
        w_rel_cnt  = r_rel_cnt;

        unique case (r_state)
            StLoad: begin
                // A strobe on the cycle download falls is still taken.
                if (bus.ioctl_wr) begin
                    if (bus.ioctl_addr < SizeAddr) begin
                        w_we   = 1'b1;
                        w_addr = bus.ioctl_addr[12:0];
                        w_data = bus.ioctl_dout;
                        w_sum  = r_sum + bus.ioctl_dout;
                        if (r_count != ByteCountMax) begin
                            w_count = r_count + 14'd1;
                        end
                        if (w_addr_next > r_fill_ptr) begin
                            w_fill_ptr = w_addr_next;
                        end
                    end else begin
                        w_overflow = 1'b1;
                    end
                end
                if (!bus.ioctl_download) begin
                    w_state = StFill;
                end
            end
            StFill: begin
                w_rel_cnt = '0;
                if (r_fill_ptr < SizePtr) begin
                    w_we       = 1'b1;
                    w_addr     = r_fill_ptr[12:0];
                    w_data     = FillByte;
                    w_fill_ptr = w_fill_inc;
                    if (w_fill_inc == SizePtr) begin
                        w_state = StRelease;
                    end
                end else begin
                    w_state = StRelease;
                end
            end
            StRelease: begin
                if (r_rel_cnt == HoldLast) begin
                    w_state = StDone;
                end else begin
                    w_rel_cnt = r_rel_cnt + 16'd1;
                end
            end
            StIdle, StDone: begin
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        if (w_sel_rise && (r_state != StLoad)) begin
            w_state    = StLoad;
            w_we       = 1'b0;
            w_overflow = 1'b0;
            w_count    = '0;
            w_sum      = '0;
            w_fill_ptr = '0;
            w_rel_cnt  = '0;
        end
    end

    assign bus.ipl_we   = r_we;
    assign bus.ipl_addr = r_addr;
    assign bus.ipl_data = r_data;

    assign cpu_hold   = (r_state != StDone);
    assign loaded     = (r_state == StDone);
    assign overflow   = r_overflow;
    assign byte_count = r_count;
    assign checksum   = r_sum;

endmodule

// File: doc/x1_ipl_loader.md
X1_IPL_LOADER -- requirements
Module: x1_ipl_loader

Interface
REQ-001 Parameter INDEX, default 8'h00: ioctl_index value that selects the IPL image.
REQ-002 Parameter SIZE, default 4096: IPL window in bytes, a power of two, at most 8192.
REQ-003 Parameter HOLD, default 16: number of clk_sys cycles cpu_hold stays high after the fill completes.
REQ-004 clk_sys  in  1  system clock; the only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_download  in  1  high while the host is streaming a file.
REQ-007 ioctl_index  in  8  file index of the current download.
REQ-008 ioctl_wr  in  1  one-cycle strobe; ioctl_addr and ioctl_dout are valid while it is high.
REQ-009 ioctl_addr  in  25  byte offset of the strobed byte.
REQ-010 ioctl_dout  in  8  strobed data byte.
REQ-011 ipl_we  out  1  write strobe to the IPL dpram port A.
REQ-012 ipl_addr  out  13  IPL dpram write address.
REQ-013 ipl_data  out  8  IPL dpram write data.
REQ-014 cpu_hold  out  1  high holds the Z80 and sub CPU in reset.
REQ-015 loaded  out  1  high when a valid image occupies the full window.
REQ-016 overflow  out  1  sticky flag: a selected byte had ioctl_addr >= SIZE.
REQ-017 byte_count  out  14  number of bytes accepted in the current or last load.
REQ-018 checksum  out  8  modulo-256 sum of the accepted bytes.

Function
REQ-019 The block is an FSM with states IDLE, LOAD, FILL, RELEASE and DONE.
REQ-020 IDLE -> LOAD when ioctl_download=1 and ioctl_index=INDEX.
- On that entry: cpu_hold=1, loaded=0, overflow=0, byte_count=0, checksum=0, fill pointer=0.
REQ-021 A download with any other index is ignored in every state, with no output change.
REQ-022 In LOAD, each ioctl_wr with ioctl_addr<SIZE is accepted.
- Exactly one cycle later: ipl_we=1, ipl_addr=ioctl_addr[12:0], ipl_data=ioctl_dout.
- In the same update: byte_count+1, checksum+ioctl_dout (wrapping), fill pointer = max(fill pointer, addr+1).
REQ-023 In LOAD, ioctl_wr with ioctl_addr>=SIZE: no write, no count or checksum change, overflow<=1.
REQ-024 ipl_we shall be a single-cycle pulse per accepted byte; it is low in every other cycle of LOAD.
REQ-025 LOAD -> FILL on the first cycle with ioctl_download=0.
- A final strobe coincident with that falling edge is still accepted.
REQ-026 FILL writes 8'hFF, one byte per cycle, from the fill pointer up to SIZE-1.
- ipl_we is held high for these cycles.
- If fill pointer = SIZE, FILL lasts one cycle with no write.
REQ-027 FILL -> RELEASE after the last fill write; RELEASE counts HOLD cycles, then -> DONE.
REQ-028 DONE: cpu_hold=0, loaded=1.
- A new selected download -> LOAD with the REQ-020 entry actions.
REQ-029 A selected download rising in FILL or RELEASE aborts that state and re-enters LOAD with the REQ-020 actions.
- Any pending fill write is abandoned.
REQ-030 byte_count counts duplicate addresses each time they are accepted; it saturates at 16383.
REQ-031 loaded=1 while overflow=1 is allowed; software checks the overflow flag.

Reset
REQ-032 On reset: state=IDLE, ipl_we=0, ipl_addr=0, ipl_data=0, cpu_hold=1, loaded=0, overflow=0, byte_count=0, checksum=0, release counter=0.
REQ-033 Reset mid-LOAD or mid-FILL discards progress.
- A download still active after reset is not resumed; the next selected rising download restarts.

Structure
REQ-034 FSM state encoding and the fill byte 8'hFF shall live in the shared package x1_pkg.
REQ-035 The block is a single module with no sub-module instances.
- Top-level muxing of ipl_* with the boot ROM address path stays outside this block.

Verification
REQ-036 Load 4096 bytes, value = addr[7:0], index 0.
- Expect: 4096 ipl_we pulses, each one cycle after its strobe.
- Expect: checksum=8'h00, byte_count=4096, no fill writes.
- Expect: loaded=1 exactly HOLD+1 cycles after the fill state.
REQ-037 Load 100 bytes.
- Expect: fill writes 8'hFF to addresses 100..4095 on consecutive cycles, then cpu_hold falls after 16 cycles.
REQ-038 Load with ioctl_index=8'h01.
- Expect: no ipl_we, and cpu_hold/loaded unchanged from their reset values.
REQ-039 Stream 4100 bytes.
- Expect: 4096 writes, overflow=1, byte_count=4096, loaded=1.
REQ-040 Start a second selected download 5 cycles into FILL.
- Expect: FILL aborted, counters zeroed, cpu_hold=1, new bytes written.
REQ-041 Assert reset after 10 bytes of a load.
- Expect: all outputs equal the REQ-032 values; no writes until the next selected download.
